seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised overlapping serial sequence detector.
- Pattern, pattern length and output mode (Moore/Mealy) are runtime-programmable.
- Sits downstream of the serial bit source; next generation of the fixed-pattern, fixed-mode detector and its single-bit state flops.
- Adds bit-valid qualification, fill tracking, a saturating match counter and configuration-error flagging.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (legal 2..16).
- LEN_W, 4: width of pat_len; must hold MAX_LEN.
- CNT_W, 8: width of match_cnt.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  din is valid this cycle; the bit is accepted on the rising edge.
- din  input  1  serial data bit.
- pattern  input  MAX_LEN  target sequence. Bit pat_len-1 is the first bit received; bit 0 is the last.
- pat_len  input  LEN_W  active pattern length.
- mode  input  1  0 = Moore, 1 = Mealy.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  detection indication.
- match_cnt  output  CNT_W  number of detections since reset/clear, saturating.
- cfg_err  output  1  pat_len outside 1..MAX_LEN.

Behaviour:
- Reset (async, immediate): history=0, fill=0, moore_q=0, match_cnt=0; match=0, cfg_err reflects inputs combinationally.
- History: MAX_LEN-bit shift register. On each accepted bit: hist <= {hist[MAX_LEN-2:0], din}. Holds when en=0.
- Fill counter: increments per accepted bit, saturates at MAX_LEN. Prevents false matches on reset zeros.
- Configuration:
  - cfg_err = (pat_len==0) || (pat_len>MAX_LEN).
  - While cfg_err=1: no detections, match_cnt frozen, moore_q cleared on the next accepted bit.
- Hit (combinational): hit = en && !cfg_err && (fill+1 >= pat_len) && (lowest pat_len bits of {hist,din} == pattern[pat_len-1:0]).
  - Compare uses the incoming bit, so overlap is inherent. The history is never flushed on a match.
- Mealy (mode=1): match = hit.
  - Same cycle as the final bit; zero latency; combinational from din/en.
- Moore (mode=0): moore_q <= hit on each accepted edge; holds while en=0. match = moore_q.
  - Asserted the cycle after the final bit. Stays high until the next accepted bit.
- moore_q is updated in both modes. A mode switch takes effect immediately on match; no state loss.
- match_cnt:
  - On an accepted edge with hit=1, increments by 1 and saturates at 2^CNT_W-1.
  - clr_cnt=1 forces 0 and has priority over a simultaneous hit (result 0).
  - Counting is identical in both modes.
- Pattern/pat_len changes mid-stream: history and fill are retained. The new pattern applies from the next compare.
- Reset mid-sequence: partial match discarded. At least pat_len new bits are required before the next match.

Decomposition:
- Shared package seq_det_pkg:
  - MODE_MOORE=1'b0, MODE_MEALY=1'b1.
  - Default MAX_LEN/LEN_W/CNT_W constants.
- Sub-module dff_vec: parametrised-width D register with enable and async active-high reset to 0.
  - Used for hist, fill, moore_q and match_cnt storage.

Test Plan:
- Mealy overlap: pattern=4'b1011, pat_len=4, mode=1, en=1, din stream 1,0,1,1,0,1,1 -> match high in the same cycle as bits 4 and 7; match_cnt=2.
- Moore overlap: same stream with mode=0 -> match high the cycle after bits 4 and 7; match_cnt=2.
- Fill guard: pattern=0, pat_len=4, mode=1, din=0 after reset -> no match for bits 1-3; match on bit 4; match every cycle thereafter.
- en gating in Moore: after a match, drop en for 5 cycles -> match held high, no count change; resume with din=0 -> match drops.
- Config and counter:
  - pat_len=0 -> cfg_err=1, no matches.
  - CNT_W=2 with 5 detections -> match_cnt=3.
  - clr_cnt coincident with a hit -> match_cnt=0.
- Reset mid-operation: pattern=1011, feed 1,0,1, assert reset, feed 1 -> no match; match_cnt=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial sequence detector.
// Holds output-mode encodings and default sizing.
package seq_det_pkg;

    localparam logic MODE_MOORE = 1'b0;
    localparam logic MODE_MEALY = 1'b1;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/dff_vec.sv
// Parametrised-width D register with load enable.
// Asynchronous active-high reset clears the contents to zero.
module dff_vec #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture i_d on enabled edges; clear immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/seq_detect_param.sv
// Overlapping serial sequence detector with runtime pattern,
// length and Moore/Mealy output selection plus a match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               mode,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_moore;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_hist_d;
    logic [FILL_W-1:0]  w_fill_d;
    logic [CNT_W-1:0]   w_cnt_d;
    logic               w_cnt_en;
    logic [MAX_LEN:0]   w_window;
    logic [MAX_LEN:0]   w_pat;
    logic [MAX_LEN:0]   w_mask;
    logic               w_bits_eq;
    logic               w_fill_ok;
    logic               w_cfg_err;
    logic               w_hit;

    // Select the low pat_len positions of the incoming window.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i <= MAX_LEN; i++) begin
            w_mask[i] = (i < int'(pat_len));
        end
    end

    // The window includes din, so overlap needs no special case.
    assign w_window  = {r_hist, din};
    assign w_pat     = {1'b0, pattern};
    assign w_bits_eq = (((w_window ^ w_pat) & w_mask) == '0);

    assign w_cfg_err = (pat_len == '0) ||
                       (int'(pat_len) > MAX_LEN);

    // Suppress matches against the zeros left by reset.
    assign w_fill_ok = (int'(r_fill) + 1) >= int'(pat_len);

    assign w_hit = en && !w_cfg_err && w_fill_ok && w_bits_eq;

    assign w_hist_d = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_d = (r_fill == FILL_W'(MAX_LEN)) ?
                      r_fill : r_fill + 1'b1;

    // Clear wins over a coincident hit; count saturates.
    assign w_cnt_en = clr_cnt || w_hit;
    assign w_cnt_d  = clr_cnt  ? '0    :
                      (&r_cnt) ? r_cnt :
                      r_cnt + 1'b1;

    dff_vec #(.W(MAX_LEN)) u_hist (
        .clk   (clk),
        .reset (reset),
        .i_en  (en),
        .i_d   (w_hist_d),
        .o_q   (r_hist)
    );

    dff_vec #(.W(FILL_W)) u_fill (
        .clk   (clk),
        .reset (reset),
        .i_en  (en),
        .i_d   (w_fill_d),
        .o_q   (r_fill)
    );

    dff_vec #(.W(1)) u_moore (
        .clk   (clk),
        .reset (reset),
        .i_en  (en),
        .i_d   (w_hit),
        .o_q   (r_moore)
    );

    dff_vec #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_cnt_en),
        .i_d   (w_cnt_d),
        .o_q   (r_cnt)
    );

    assign match     = (mode == MODE_MEALY) ? w_hit : r_moore;
    assign match_cnt = r_cnt;
    assign cfg_err   = w_cfg_err;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios and random
// traffic checked against a bit-history reference model.
module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       din;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       mode;
    logic       clr_cnt;
    logic       match;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       match2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;

    int n_checks = 0;
    int n_pass   = 0;

    bit q[$];
    bit m_moore;
    int m_cnt;
    int m_cnt2;

    seq_detect_param dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .din       (din),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .mode      (mode),
        .clr_cnt   (clr_cnt),
        .match     (match),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .din       (din),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .mode      (mode),
        .clr_cnt   (clr_cnt),
        .match     (match2),
        .match_cnt (match_cnt2),
        .cfg_err   (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: last pat_len received bits, oldest = pattern[n-1].
    function automatic bit m_hit(bit e, bit d);
        int n;
        bit ok;
        bit b;
        if (!e) return 1'b0;
        n = int'(pat_len);
        if (n == 0 || n > 8) return 1'b0;
        if (q.size() + 1 < n) return 1'b0;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? d : q[q.size() - k];
            if (b != pattern[k]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic bit m_match();
        return mode ? m_hit(en, din) : m_moore;
    endfunction

    task automatic model_reset();
        q.delete();
        m_moore = 1'b0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic set_in(input bit e, input bit d);
        en  = e;
        din = d;
        #1;
    endtask

    task automatic tick();
        bit h;
        h = m_hit(en, din);
        @(posedge clk);
        if (en) begin
            q.push_back(din);
            if (q.size() > 16) void'(q.pop_front());
            m_moore = h;
        end
        if (clr_cnt) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (h) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        en      = 1'b0;
        din     = 1'b0;
        clr_cnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        pat_len = 4'd4;
        #1;
        n_checks++;
        if (match !== 1'b0)
            $display("FAIL reset_match got %b want 0", match);
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd0)
            $display("FAIL reset_cnt got %0d want 0", match_cnt);
        else n_pass++;
        n_checks++;
        if (cfg_err !== 1'b0)
            $display("FAIL reset_cfg_ok got %b want 0", cfg_err);
        else n_pass++;
        pat_len = 4'd0;
        #1;
        n_checks++;
        if (cfg_err !== 1'b1)
            $display("FAIL reset_cfg_err got %b want 1", cfg_err);
        else n_pass++;
        pat_len = 4'd4;
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_mealy_overlap();
        bit bits [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit expm [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_reset();
        pattern = 8'h0B;
        pat_len = 4'd4;
        mode    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, bits[i]);
            n_checks++;
            if (match !== expm[i])
                $display("FAIL mealy_bit%0d got %b want %b",
                         i + 1, match, expm[i]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (match_cnt !== 8'd2)
            $display("FAIL mealy_cnt got %0d want 2", match_cnt);
        else n_pass++;
    endtask

    task automatic test_moore_overlap();
        bit bits [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit expm [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_reset();
        pattern = 8'h0B;
        pat_len = 4'd4;
        mode    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, bits[i]);
            tick();
            n_checks++;
            if (match !== expm[i])
                $display("FAIL moore_after_bit%0d got %b want %b",
                         i + 1, match, expm[i]);
            else n_pass++;
        end
        n_checks++;
        if (match_cnt !== 8'd2)
            $display("FAIL moore_cnt got %0d want 2", match_cnt);
        else n_pass++;
    endtask

    task automatic test_fill_guard();
        do_reset();
        pattern = 8'h00;
        pat_len = 4'd4;
        mode    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0);
            n_checks++;
            if (match !== (i >= 3))
                $display("FAIL fill_bit%0d got %b want %b",
                         i + 1, match, (i >= 3));
            else n_pass++;
            tick();
        end
        n_checks++;
        if (match_cnt !== 8'd5)
            $display("FAIL fill_cnt got %0d want 5", match_cnt);
        else n_pass++;
    endtask

    task automatic test_en_gating();
        bit bits [4] = '{1, 0, 1, 1};
        do_reset();
        pattern = 8'h0B;
        pat_len = 4'd4;
        mode    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, bits[i]);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'($urandom_range(0, 1)));
            tick();
            n_checks++;
            if (match !== 1'b1 || match_cnt !== 8'd1)
                $display("FAIL gate_hold%0d got m=%b c=%0d want m=1 c=1",
                         i, match, match_cnt);
            else n_pass++;
        end
        set_in(1'b1, 1'b0);
        tick();
        n_checks++;
        if (match !== 1'b0)
            $display("FAIL gate_resume got %b want 0", match);
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        do_reset();
        pattern = 8'h00;
        pat_len = 4'd0;
        mode    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0);
            n_checks++;
            if (match !== 1'b0 || cfg_err !== 1'b1)
                $display("FAIL cfg_len0_bit%0d got m=%b e=%b want m=0 e=1",
                         i, match, cfg_err);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (match_cnt !== 8'd0)
            $display("FAIL cfg_cnt got %0d want 0", match_cnt);
        else n_pass++;
        pat_len = 4'd9;
        #1;
        n_checks++;
        if (cfg_err !== 1'b1 || match !== 1'b0)
            $display("FAIL cfg_len9 got e=%b m=%b want e=1 m=0",
                     cfg_err, match);
        else n_pass++;
        pat_len = 4'd4;
        #1;
        n_checks++;
        if (cfg_err !== 1'b0 || match !== 1'b1)
            $display("FAIL cfg_recover got e=%b m=%b want e=0 m=1",
                     cfg_err, match);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturate_clear();
        do_reset();
        pattern = 8'h00;
        pat_len = 4'd2;
        mode    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0);
            tick();
        end
        n_checks++;
        if (match_cnt2 !== 2'd3)
            $display("FAIL sat_cnt2 got %0d want 3", match_cnt2);
        else n_pass++;
        n_checks++;
        if (match_cnt !== 8'd5)
            $display("FAIL sat_cnt8 got %0d want 5", match_cnt);
        else n_pass++;
        clr_cnt = 1'b1;
        set_in(1'b1, 1'b0);
        n_checks++;
        if (match !== 1'b1)
            $display("FAIL clr_hit got %b want 1", match);
        else n_pass++;
        tick();
        clr_cnt = 1'b0;
        n_checks++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0)
            $display("FAIL clr_cnt got %0d/%0d want 0/0",
                     match_cnt, match_cnt2);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit bits [3] = '{1, 0, 1};
        do_reset();
        pattern = 8'h0B;
        pat_len = 4'd4;
        mode    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, bits[i]);
            tick();
        end
        en = 1'b0;
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        set_in(1'b1, 1'b1);
        n_checks++;
        if (match !== 1'b0)
            $display("FAIL rstmid_match got %b want 0", match);
        else n_pass++;
        tick();
        n_checks++;
        if (match_cnt !== 8'd0)
            $display("FAIL rstmid_cnt got %0d want 0", match_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        bit em;
        do_reset();
        pattern = 8'h05;
        pat_len = 4'd3;
        mode    = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                pattern = 8'($urandom);
                pat_len = 4'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 199) == 0) do_reset();
            clr_cnt = ($urandom_range(0, 63) == 0);
            set_in(($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
            em = m_match();
            n_checks++;
            if (match !== em || cfg_err !== (pat_len == 0 || pat_len > 8))
                $display("FAIL rand_pre c%0d got m=%b e=%b want m=%b",
                         c, match, cfg_err, em);
            else n_pass++;
            tick();
            clr_cnt = 1'b0;
            n_checks++;
            if (match_cnt !== 8'(m_cnt) || match_cnt2 !== 2'(m_cnt2))
                $display("FAIL rand_cnt c%0d got %0d/%0d want %0d/%0d",
                         c, match_cnt, match_cnt2, m_cnt, m_cnt2);
            else n_pass++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        din     = 1'b0;
        pattern = 8'h00;
        pat_len = 4'd4;
        mode    = 1'b1;
        clr_cnt = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_mealy_overlap();
        test_moore_overlap();
        test_fill_guard();
        test_en_gating();
        test_cfg_err();
        test_saturate_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
